// File: rtl/obi_master_be.sv
// Single-outstanding OBI manager: turns valid/ready commands into OBI A/R transactions.
// Optional define OBI_MGR_BE_CHECK_EN rejects empty or non-contiguous byte enables before issue.
module obi_master_be #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic                    cmd_we_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    obi_req_o,
    input  logic                    obi_gnt_i,
    output logic [ADDR_WIDTH-1:0]   obi_addr_o,
    output logic                    obi_we_o,
    output logic [DATA_WIDTH/8-1:0] obi_be_o,
    output logic [DATA_WIDTH-1:0]   obi_wdata_o,
    input  logic                    obi_rvalid_i,
    output logic                    obi_rready_o,
    input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
    input  logic                    obi_err_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        RESET = 3'd0,
        IDLE  = 3'd1,
        REQ   = 3'd2,
        RESP  = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    we_q;
    logic [BE_WIDTH-1:0]     be_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic                    cmd_fire;
    logic                    rsp_capture;
    logic                    cmd_illegal;

    assign cmd_fire    = (state_q == IDLE) && cmd_valid_i;
    assign rsp_capture = (state_q == RESP) && obi_rvalid_i;

`ifdef OBI_MGR_BE_CHECK_EN
    // A byte-enable mask is contiguous when it contains at most one run of ones.
    function automatic logic be_contiguous(input logic [BE_WIDTH-1:0] be);
        int   runs;
        logic prev;
        runs = 0;
        prev = 1'b0;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i] && !prev) begin
                runs++;
            end
            prev = be[i];
        end
        return (runs <= 1);
    endfunction

    assign cmd_illegal = (cmd_be_i == '0) ||
                         ((DATA_WIDTH == 32) && !be_contiguous(cmd_be_i));
`else
    assign cmd_illegal = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // A-channel outputs come only from these registers, never from cmd_* directly.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (cmd_fire) begin
            addr_q  <= cmd_addr_i;
            we_q    <= cmd_we_i;
            be_q    <= cmd_be_i;
            wdata_q <= cmd_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (cmd_fire && cmd_illegal) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end else if (rsp_capture) begin
            rdata_q <= we_q ? '0 : obi_rdata_i;
            err_q   <= obi_err_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_ready_o  = 1'b0;
        obi_req_o    = 1'b0;
        obi_addr_o   = '0;
        obi_we_o     = 1'b0;
        obi_be_o     = '0;
        obi_wdata_o  = '0;
        obi_rready_o = 1'b0;
        rsp_valid_o  = 1'b0;
        case (state_q)
            RESET: begin
                state_d = IDLE;
            end
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    state_d = cmd_illegal ? DONE : REQ;
                end
            end
            REQ: begin
                obi_req_o   = 1'b1;
                obi_addr_o  = addr_q;
                obi_we_o    = we_q;
                obi_be_o    = be_q;
                obi_wdata_o = wdata_q;
                if (obi_gnt_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                obi_rready_o = 1'b1;
                if (obi_rvalid_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = RESET;
            end
        endcase
    end

    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_obi_master_be.sv
// Self-checking bench for obi_master_be: behavioural OBI subordinate plus response scoreboard.
// Build with OBI_MGR_BE_CHECK_EN defined to exercise the byte-enable check path.
module tb_obi_master_be;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [31:0] cmd_addr_i;
    logic        cmd_we_i;
    logic [3:0]  cmd_be_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        obi_req_o;
    logic        obi_gnt_i;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i;
    logic        obi_rready_o;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;

    int          checks = 0;
    int          errors = 0;
    rsp_t        exp_q[$];
    logic [31:0] ref_mem[16];
    logic [31:0] sub_mem[16];
    int          gnt_delay = 0;
    int          rvalid_delay = 0;
    logic        err_next = 1'b0;
    logic        stray = 1'b0;
    int          req_count = 0;
    time         last_accept = 0;

    obi_master_be #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_we_i     (cmd_we_i),
        .cmd_be_i     (cmd_be_i),
        .cmd_wdata_i  (cmd_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .obi_req_o    (obi_req_o),
        .obi_gnt_i    (obi_gnt_i),
        .obi_addr_o   (obi_addr_o),
        .obi_we_o     (obi_we_o),
        .obi_be_o     (obi_be_o),
        .obi_wdata_o  (obi_wdata_o),
        .obi_rvalid_i (obi_rvalid_i),
        .obi_rready_o (obi_rready_o),
        .obi_rdata_i  (obi_rdata_i),
        .obi_err_i    (obi_err_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // Subordinate: grants after gnt_delay cycles, answers after rvalid_delay, and polices the A-channel.
    initial begin : subordinate
        int          gcnt;
        int          rcnt;
        logic        pend;
        logic [31:0] pend_data;
        logic [3:0]  idx;
        gcnt = 0;
        rcnt = 0;
        pend = 1'b0;
        pend_data = '0;
        obi_gnt_i = 1'b0;
        obi_rvalid_i = 1'b0;
        obi_rdata_i = '0;
        obi_err_i = 1'b0;
        forever begin
            @(negedge clk_i);
            obi_gnt_i = 1'b0;
            obi_rvalid_i = 1'b0;
            obi_rdata_i = '0;
            obi_err_i = 1'b0;
            if (!reset_ni) begin
                pend = 1'b0;
                gcnt = 0;
                rcnt = 0;
            end else begin
                checks++;
                if (!obi_req_o && ({obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o} !== '0)) begin
                    errors++;
                    $display("[TB] FAIL a_chan_idle_zero got addr=%h we=%b be=%b wdata=%h expected all 0",
                             obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o);
                end
                checks++;
                if ((obi_req_o && pend) !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL req_while_pending got req=1 expected req=0 before prior rvalid");
                end
                if (stray) begin
                    obi_gnt_i = 1'b1;
                    obi_rvalid_i = 1'b1;
                    obi_rdata_i = 32'h55AA_55AA;
                    obi_err_i = 1'b1;
                end else if (pend) begin
                    if (rcnt >= rvalid_delay) begin
                        obi_rvalid_i = 1'b1;
                        obi_rdata_i = pend_data;
                        obi_err_i = err_next;
                        pend = 1'b0;
                        rcnt = 0;
                    end else begin
                        rcnt++;
                    end
                end else if (obi_req_o) begin
                    if (gcnt >= gnt_delay) begin
                        obi_gnt_i = 1'b1;
                        gcnt = 0;
                        pend = 1'b1;
                        req_count++;
                        idx = obi_addr_o[5:2];
                        if (obi_we_o) begin
                            sub_mem[idx] = merge(sub_mem[idx], obi_wdata_o, obi_be_o);
                            pend_data = 32'hFFFF_FFFF;
                        end else begin
                            pend_data = sub_mem[idx];
                        end
                    end else begin
                        gcnt++;
                    end
                end
            end
        end
    end

    // Response side of the scoreboard: pops one expectation per rsp handshake.
    initial begin : consumer
        rsp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (reset_ni && rsp_valid_o && rsp_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rsp_unexpected got rsp_valid=1 expected no pending response");
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (rsp_rdata_o !== e.rdata) begin
                        errors++;
                        $display("[TB] FAIL rsp_rdata got %h expected %h", rsp_rdata_o, e.rdata);
                    end
                    checks++;
                    if (rsp_err_o !== e.err) begin
                        errors++;
                        $display("[TB] FAIL rsp_err got %b expected %b", rsp_err_o, e.err);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Called at a negedge; returns at the negedge after the accepting posedge with cmd_valid still high.
    task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata, input logic illegal);
        int         n;
        logic [3:0] idx;
        rsp_t       e;
        cmd_valid_i = 1'b1;
        cmd_addr_i = addr;
        cmd_we_i = we;
        cmd_be_i = be;
        cmd_wdata_i = wdata;
        n = 0;
        while (!cmd_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL accept_timeout got cmd_ready=%b expected 1 within 50 cycles", cmd_ready_o);
        end else begin
            idx = addr[5:2];
            if (illegal) begin
                e = '{rdata: 32'h0, err: 1'b1};
            end else if (we) begin
                ref_mem[idx] = merge(ref_mem[idx], wdata, be);
                e = '{rdata: 32'h0, err: err_next};
            end else begin
                e = '{rdata: ref_mem[idx], err: err_next};
            end
            exp_q.push_back(e);
            last_accept = $time;
        end
        @(negedge clk_i);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        checks++;
        if ({cmd_ready_o, obi_req_o, obi_rready_o, rsp_valid_o, obi_we_o, rsp_err_o} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b expected 000000",
                     {cmd_ready_o, obi_req_o, obi_rready_o, rsp_valid_o, obi_we_o, rsp_err_o});
        end
        checks++;
        if ({obi_addr_o, obi_be_o, obi_wdata_o, rsp_rdata_o} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data got addr=%h be=%b wdata=%h rdata=%h expected 0",
                     obi_addr_o, obi_be_o, obi_wdata_o, rsp_rdata_o);
        end
        reset_ni = 1'b1;
        checks++;
        if (cmd_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state_ready got %b expected 0", cmd_ready_o);
        end
        @(negedge clk_i);
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL idle_ready got %b expected 1", cmd_ready_o);
        end
    endtask

    task automatic test_read();
        rsp_ready_i = 1'b1;
        issue(32'h10, 1'b0, 4'hF, 32'h0, 1'b0);
        cmd_valid_i = 1'b0;
        checks++;
        if ({obi_req_o, obi_we_o, obi_addr_o, obi_be_o} !== {1'b1, 1'b0, 32'h10, 4'hF}) begin
            errors++;
            $display("[TB] FAIL read_a_chan got req=%b we=%b addr=%h be=%b expected 1 0 00000010 1111",
                     obi_req_o, obi_we_o, obi_addr_o, obi_be_o);
        end
        @(negedge clk_i);
        checks++;
        if ({obi_rready_o, obi_req_o, rsp_valid_o} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL read_resp_phase got rready/req/rsp_valid=%b expected 100",
                     {obi_rready_o, obi_req_o, rsp_valid_o});
        end
        @(negedge clk_i);
        checks++;
        if ({rsp_valid_o, rsp_rdata_o} !== {1'b1, 32'hDEAD_BEEF}) begin
            errors++;
            $display("[TB] FAIL read_latency got valid=%b rdata=%h expected 1 deadbeef",
                     rsp_valid_o, rsp_rdata_o);
        end
        wait_drain();
    endtask

    task automatic test_write_stall();
        gnt_delay = 5;
        issue(32'h20, 1'b1, 4'b0011, 32'h1234_ABCD, 1'b0);
        cmd_valid_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({obi_req_o, obi_we_o, obi_addr_o, obi_be_o, obi_wdata_o} !==
                {1'b1, 1'b1, 32'h20, 4'b0011, 32'h1234_ABCD}) begin
                errors++;
                $display("[TB] FAIL stall_a_chan cycle %0d got req=%b we=%b addr=%h be=%b wdata=%h expected 1 1 00000020 0011 1234abcd",
                         i, obi_req_o, obi_we_o, obi_addr_o, obi_be_o, obi_wdata_o);
            end
            @(negedge clk_i);
        end
        checks++;
        if (obi_req_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_req_drop got %b expected 0", obi_req_o);
        end
        wait_drain();
        gnt_delay = 0;
    endtask

    task automatic test_backpressure_err();
        err_next = 1'b1;
        rsp_ready_i = 1'b0;
        issue(32'h30, 1'b0, 4'hF, 32'h0, 1'b0);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({rsp_valid_o, rsp_err_o, cmd_ready_o, obi_req_o} !== 4'b1100) begin
                errors++;
                $display("[TB] FAIL hold_done cycle %0d got valid/err/cmd_ready/req=%b expected 1100",
                         i, {rsp_valid_o, rsp_err_o, cmd_ready_o, obi_req_o});
            end
            @(negedge clk_i);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({cmd_ready_o, rsp_valid_o, rsp_err_o} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL after_release got cmd_ready/valid/err=%b expected 101",
                     {cmd_ready_o, rsp_valid_o, rsp_err_o});
        end
        wait_drain();
        err_next = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  base;
        time t_prev;
        base = req_count;
        t_prev = 0;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue(32'h08 + 32'(i) * 32'h4, 1'b0, 4'hF, 32'h0, 1'b0);
            if (i > 0) begin
                checks++;
                if ((last_accept - t_prev) !== 64'd40) begin
                    errors++;
                    $display("[TB] FAIL b2b_spacing got %0t expected 40", last_accept - t_prev);
                end
            end
            t_prev = last_accept;
        end
        cmd_valid_i = 1'b0;
        wait_drain();
        checks++;
        if (req_count - base !== 8) begin
            errors++;
            $display("[TB] FAIL b2b_handshakes got %0d expected 8", req_count - base);
        end
    endtask

    task automatic test_reset_mid();
        rvalid_delay = 3;
        issue(32'h14, 1'b0, 4'hF, 32'h0, 1'b0);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        #1 reset_ni = 1'b0;
        #1;
        checks++;
        if ({cmd_ready_o, obi_req_o, obi_rready_o, rsp_valid_o, rsp_err_o, obi_addr_o, rsp_rdata_o} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset got ready=%b req=%b rready=%b valid=%b err=%b addr=%h rdata=%h expected 0",
                     cmd_ready_o, obi_req_o, obi_rready_o, rsp_valid_o, rsp_err_o, obi_addr_o, rsp_rdata_o);
        end
        exp_q.delete();
        rvalid_delay = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        #1 reset_ni = 1'b1;
        stray = 1'b1;
        checks++;
        if (cmd_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_state got cmd_ready=%b expected 0", cmd_ready_o);
        end
        @(negedge clk_i);
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_idle got cmd_ready=%b expected 1", cmd_ready_o);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            checks++;
            if ({rsp_valid_o, rsp_err_o, rsp_rdata_o, obi_rready_o, obi_req_o, cmd_ready_o} !==
                {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("[TB] FAIL stray_rvalid got valid=%b err=%b rdata=%h rready=%b req=%b ready=%b expected 0 0 0 0 0 1",
                         rsp_valid_o, rsp_err_o, rsp_rdata_o, obi_rready_o, obi_req_o, cmd_ready_o);
            end
        end
        stray = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        issue(32'h10, 1'b0, 4'hF, 32'h0, 1'b0);
        cmd_valid_i = 1'b0;
        wait_drain();
    endtask

    task automatic test_be_check();
        int base;
        base = req_count;
`ifdef OBI_MGR_BE_CHECK_EN
        issue(32'h40, 1'b0, 4'b0000, 32'h0, 1'b1);
        cmd_valid_i = 1'b0;
        checks++;
        if ({rsp_valid_o, rsp_err_o, rsp_rdata_o, obi_req_o} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL be_zero got valid=%b err=%b rdata=%h req=%b expected 1 1 0 0",
                     rsp_valid_o, rsp_err_o, rsp_rdata_o, obi_req_o);
        end
        wait_drain();
        issue(32'h44, 1'b1, 4'b0101, 32'hCAFE_F00D, 1'b1);
        cmd_valid_i = 1'b0;
        checks++;
        if ({rsp_valid_o, rsp_err_o, rsp_rdata_o, obi_req_o} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL be_gap got valid=%b err=%b rdata=%h req=%b expected 1 1 0 0",
                     rsp_valid_o, rsp_err_o, rsp_rdata_o, obi_req_o);
        end
        wait_drain();
        checks++;
        if (req_count - base !== 0) begin
            errors++;
            $display("[TB] FAIL be_illegal_no_req got %0d expected 0", req_count - base);
        end
        issue(32'h10, 1'b0, 4'b1100, 32'h0, 1'b0);
        cmd_valid_i = 1'b0;
        wait_drain();
`else
        issue(32'h44, 1'b1, 4'b0101, 32'hCAFE_F00D, 1'b0);
        cmd_valid_i = 1'b0;
        wait_drain();
`endif
        checks++;
        if (req_count - base !== 1) begin
            errors++;
            $display("[TB] FAIL be_legal_issue got %0d expected 1", req_count - base);
        end
    endtask

    initial begin
        cmd_valid_i = 1'b0;
        cmd_addr_i = '0;
        cmd_we_i = 1'b0;
        cmd_be_i = '0;
        cmd_wdata_i = '0;
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0203;
        end
        ref_mem[4] = 32'hDEAD_BEEF;
        for (int i = 0; i < 16; i++) begin
            sub_mem[i] = ref_mem[i];
        end
        $display("[TB] starting obi_master_be bench");
        test_reset();
        test_read();
        test_write_stall();
        test_backpressure_err();
        test_back_to_back();
        test_reset_mid();
        test_be_check();
        repeat (2) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
